// File: rtl/ultra_scan_ctrl.sv
// ultra_scan_ctrl: time-shares one echo-timing engine across N_SENS ultrasonic rangers.
// The sensors are triggered in round-robin order. Each echo pulse width is converted to
// centimetres with a cycle prescaler, so no divider is needed, and one tagged result is
// published per measurement.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   run         - level; keep scanning while high, stop after the current measurement
//   en_mask     - per-sensor enable, sampled only when the next sensor is selected
//   echo        - asynchronous echo pins, one per sensor
//   trigger     - trigger pins; at most one bit is high at a time
//   busy        - high whenever the controller is not idle
//   valid       - one-cycle strobe; sens_id/dist_cm/timeout hold until the next strobe
//   sens_id     - sensor index of the result
//   dist_cm     - distance in cm; all ones on timeout
//   timeout     - result is a timeout
//   last_dist   - (ULTRA_LAST_REGS_EN only) latest result per sensor, DW bits per slice
//
// Build option: define ULTRA_LAST_REGS_EN to add the per-sensor last_dist registers.
module ultra_scan_ctrl #(
  parameter int unsigned N_SENS      = 4,
  parameter int unsigned TRIG_CYC    = 500,
  parameter int unsigned CYC_PER_CM  = 2900,
  parameter int unsigned TIMEOUT_CYC = 1900000,
  parameter int unsigned GUARD_CYC   = 3000000,
  parameter int unsigned DW          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [N_SENS-1:0]    en_mask,
  input  logic [N_SENS-1:0]    echo,
  output logic [N_SENS-1:0]    trigger,
  output logic                 busy,
  output logic                 valid,
  output logic [2:0]           sens_id,
  output logic [DW-1:0]        dist_cm,
`ifdef ULTRA_LAST_REGS_EN
  output logic [N_SENS*DW-1:0] last_dist,
`endif
  output logic                 timeout
);

  typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StGuard} state_e;

  // The cm counter saturates one below all-ones, so all-ones stays reserved for timeouts.
  localparam logic [DW-1:0] CmSat = {{(DW-1){1'b1}}, 1'b0};

  state_e                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           presc_q, presc_d;
  logic [DW-1:0]         cm_q, cm_d;
  logic [2:0]            sel_q, sel_d;
  logic [2:0]            ptr_q, ptr_d;
  logic [N_SENS-1:0]     echo_m_q, echo_s_q;
  logic                  valid_q, valid_d;
  logic [2:0]            sens_id_q, sens_id_d;
  logic [DW-1:0]         dist_q, dist_d;
  logic                  timeout_q, timeout_d;
`ifdef ULTRA_LAST_REGS_EN
  logic [N_SENS*DW-1:0]  last_q, last_d;
`endif

  logic                  echo_sel;
  logic [2:0]            pick_idx;
  logic                  pick_found;
  logic                  emit, emit_to;
  logic [DW-1:0]         cm_inc;

  // (base + off) mod N_SENS, with off < N_SENS.
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_SENS) s = s - N_SENS;
    return s[2:0];
  endfunction

  function automatic logic bit_at(input logic [N_SENS-1:0] v, input logic [2:0] idx);
    logic b;
    b = 1'b0;
    for (int unsigned j = 0; j < N_SENS; j++) begin
      if (idx == 3'(j)) b = v[j];
    end
    return b;
  endfunction

  // First enabled sensor at or after the round-robin pointer.
  always_comb begin
    pick_idx   = ptr_q;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < N_SENS; i++) begin
      if (!pick_found && bit_at(en_mask, wrap_idx(ptr_q, i))) begin
        pick_idx   = wrap_idx(ptr_q, i);
        pick_found = 1'b1;
      end
    end
  end

  assign echo_sel = bit_at(echo_s_q, sel_q);

  // The cm count including this cycle's tick, so a W-cycle echo reads floor(W / CYC_PER_CM).
  always_comb begin
    cm_inc = cm_q;
    if (presc_q == 32'(CYC_PER_CM - 1) && cm_q != CmSat) cm_inc = cm_q + 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      presc_q   <= '0;
      cm_q      <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      echo_m_q  <= '0;
      echo_s_q  <= '0;
      valid_q   <= 1'b0;
      sens_id_q <= '0;
      dist_q    <= '0;
      timeout_q <= 1'b0;
`ifdef ULTRA_LAST_REGS_EN
      last_q    <= '1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      cm_q      <= cm_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      echo_m_q  <= echo;
      echo_s_q  <= echo_m_q;
      valid_q   <= valid_d;
      sens_id_q <= sens_id_d;
      dist_q    <= dist_d;
      timeout_q <= timeout_d;
`ifdef ULTRA_LAST_REGS_EN
      last_q    <= last_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    presc_d   = presc_q;
    cm_d      = cm_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    valid_d   = 1'b0;
    sens_id_d = sens_id_q;
    dist_d    = dist_q;
    timeout_d = timeout_q;
`ifdef ULTRA_LAST_REGS_EN
    last_d    = last_q;
`endif
    emit      = 1'b0;
    emit_to   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (run && pick_found) begin
          state_d = StTrig;
          sel_d   = pick_idx;
        end
      end
      StTrig: begin
        if (cnt_q == 32'(TRIG_CYC - 1)) begin
          state_d = StWaitRise;
          cnt_d   = '0;
        end
      end
      StWaitRise: begin
        if (echo_sel) begin
          state_d = StMeasure;
          cnt_d   = '0;
          presc_d = '0;
          cm_d    = '0;
        end else if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
          emit    = 1'b1;
          emit_to = 1'b1;
        end
      end
      StMeasure: begin
        presc_d = (presc_q == 32'(CYC_PER_CM - 1)) ? '0 : presc_q + 32'd1;
        cm_d    = cm_inc;
        if (!echo_sel) begin
          emit = 1'b1;
        end else if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
          emit    = 1'b1;
          emit_to = 1'b1;
        end
      end
      StGuard: begin
        if (cnt_q == 32'(GUARD_CYC - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (emit) begin
      state_d   = StGuard;
      cnt_d     = '0;
      ptr_d     = wrap_idx(sel_q, 1);
      valid_d   = 1'b1;
      sens_id_d = sel_q;
      timeout_d = emit_to;
      dist_d    = emit_to ? '1 : cm_inc;
`ifdef ULTRA_LAST_REGS_EN
      for (int unsigned i = 0; i < N_SENS; i++) begin
        if (sel_q == 3'(i)) last_d[i*DW +: DW] = dist_d;
      end
`endif
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != StIdle);
    for (int unsigned i = 0; i < N_SENS; i++) begin
      trigger[i] = (state_q == StTrig) && (sel_q == 3'(i));
    end
    valid     = valid_q;
    sens_id   = sens_id_q;
    dist_cm   = dist_q;
    timeout   = timeout_q;
`ifdef ULTRA_LAST_REGS_EN
    last_dist = last_q;
`endif
  end

endmodule
